// File: rtl/byte_transmitter.sv
// LSB-first serializer for the TAP IDCODE path: captures a word on the first
// enabled TCK edge, presents one bit per enabled edge, then raises a sticky done.
module byte_transmitter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_tck,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk_tck) begin
        if (reset) begin
            state <= IDLE;
            out   <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out <= 1'b0;
                    if (enable) begin
                        shreg <= in;
                        out   <= in[0];
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cnt is the index of the next bit to present; LAST means all bits are out
                    if (enable) begin
                        if (cnt == LAST) begin
                            out   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            out <= shreg[cnt[IW-1:0]];
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    out  <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_byte_transmitter.sv
// Bench for byte_transmitter: directed scenarios plus random traffic, checked
// against a model that tracks only the captured word and enabled-edge count.
module tb_byte_transmitter;
    localparam int W = 32;

    logic         clk_tck = 1'b0;
    logic         reset   = 1'b1;
    logic         enable  = 1'b0;
    logic [W-1:0] din     = '0;
    logic         out;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: word captured at start, number of enabled edges since reset
    logic [W-1:0] m_word = '0;
    int           m_n    = 0;
    logic         exp_out;
    logic         exp_done;

    byte_transmitter #(.WIDTH(W)) dut (
        .clk_tck(clk_tck),
        .reset  (reset),
        .enable (enable),
        .in     (din),
        .out    (out),
        .done   (done)
    );

    always #5 clk_tck = ~clk_tck;

    task automatic step(input logic r, input logic e, input logic [W-1:0] d);
        reset  = r;
        enable = e;
        din    = d;
        @(posedge clk_tck);
        if (r) begin
            m_n = 0;
        end else if (e && m_n <= W) begin
            if (m_n == 0) m_word = d;
            m_n++;
        end
        exp_out  = (m_n >= 1 && m_n <= W) ? m_word[m_n-1] : 1'b0;
        exp_done = (m_n == W + 1);
        #1;
        n_cmp++;
        assert (out === exp_out) else begin
            n_fail++;
            $error("FAIL out edge=%0d observed=%b expected=%b", m_n, out, exp_out);
        end
        n_cmp++;
        assert (done === exp_done) else begin
            n_fail++;
            $error("FAIL done edge=%0d observed=%b expected=%b", m_n, done, exp_done);
        end
    endtask

    initial begin
        logic [W-1:0] w;

        // reset dominates an asserted enable
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'hFFFF_FFFF);

        // continuous serialization of a known word
        for (int i = 0; i < W + 3; i++) step(1'b0, 1'b1, 32'h000F_AF01);
        n_cmp++;
        assert (done === 1'b1 && out === 1'b0) else begin
            n_fail++;
            $error("FAIL serialize_end observed=%b%b expected=10", done, out);
        end

        // pause after edge 5 for three cycles
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h000F_AF01);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h000F_AF01);
        for (int i = 0; i < W - 5 + 2; i++) step(1'b0, 1'b1, 32'h000F_AF01);

        // input changes after capture are ignored
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'hA5A5_A5A5);
        for (int i = 0; i < W + 1; i++) step(1'b0, 1'b1, 32'h0);

        // reset in the middle of a transmission, then a fresh capture
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h1234_5678);
        step(1'b1, 1'b1, 32'h1234_5678);
        w = $urandom;
        for (int i = 0; i < W + 2; i++) step(1'b0, 1'b1, w);

        // done is sticky regardless of enable and in
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)), $urandom);
        step(1'b1, 1'b0, '0);
        n_cmp++;
        assert (done === 1'b0) else begin
            n_fail++;
            $error("FAIL sticky_reset observed=%b expected=0", done);
        end

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) < 7), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
